// File: rtl/fifo2axis_gear.sv
// Read-side gearbox: drains a FWFT FIFO of FDW-bit words into an AXI4-Stream
// video master, releasing one output line per credited input line.
module fifo2axis_gear #(
    parameter int FDW             = 128,
    parameter int FAW             = 8,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int LINE_BEATS      = 320,
    parameter int FRAME_LINES     = 1024,
    parameter int FRAME_DELAY     = 2,
    parameter int CREDIT_W        = 4,
    parameter bit SLICE_MSB_FIRST = 1'b1,
    parameter bit WAIT_FULL_LINE  = 1'b0
) (
    input  logic                         M_AXIS_ACLK,
    input  logic                         M_AXIS_ARESETN,
    input  logic                         S_AXIS_TVALID,
    input  logic                         S_AXIS_TREADY,
    input  logic                         S_AXIS_TLAST,
    input  logic                         S_AXIS_USER,
    output logic                         M_AXIS_TVALID,
    output logic [AXIS_DATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [AXIS_DATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                         M_AXIS_TLAST,
    output logic                         M_AXIS_USER,
    input  logic                         M_AXIS_TREADY,
    output logic                         brd_rdy,
    input  logic                         brd_vld,
    input  logic [FDW-1:0]               brd_din,
    input  logic                         brd_empty,
    input  logic [FAW:0]                 brd_cnt,
    input  logic                         err_clr,
    output logic [CREDIT_W-1:0]          credit_cnt,
    output logic                         underrun_err,
    output logic                         credit_ovf
);

    // state | meaning
    // IDLE  | waiting for a line credit (and a full line in the FIFO if enabled)
    // SEND  | fetching words and emitting the beats of one line

    localparam int W   = AXIS_DATA_WIDTH;
    localparam int R   = FDW / W;
    localparam int WPL = LINE_BEATS / R;
    localparam int SW  = (R > 1) ? $clog2(R) : 1;
    localparam int BW  = $clog2(LINE_BEATS + 1);
    localparam int WW  = $clog2(WPL + 1);
    localparam int LW  = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
    localparam int FW  = 10;

    localparam logic [BW-1:0]  LAST_BEAT  = BW'(LINE_BEATS - 1);
    localparam logic [WW-1:0]  WPL_W      = WW'(WPL);
    localparam logic [FAW:0]   WPL_C      = (FAW+1)'(WPL);
    localparam logic [LW-1:0]  LAST_LINE  = LW'(FRAME_LINES - 1);
    localparam logic [FW-1:0]  FD_C       = FW'(FRAME_DELAY);
    localparam logic [SW-1:0]  LAST_SLICE = SW'(R - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state_q, state_d;
    logic [FW-1:0]         sof_cnt_q, sof_cnt_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [BW-1:0]         beat_idx_q, beat_idx_d;
    logic [WW-1:0]         words_q, words_d;
    logic [LW-1:0]         line_idx_q, line_idx_d;
    logic [FDW-1:0]        buf_q, buf_d;
    logic                  buf_valid_q, buf_valid_d;
    logic                  underrun_q, underrun_d;
    logic                  ovf_q, ovf_d;

    logic                  in_hs, credit_evt, start, tvalid, tx, line_end;
    logic                  last_slice, fetch_ok, pop, underrun_set;
    logic [SW-1:0]         slice;
    logic [W-1:0]          beat_sel [2**SW];
    logic                  unused_empty;

    assign unused_empty = brd_empty;

    assign in_hs      = S_AXIS_TVALID & S_AXIS_TREADY;
    assign credit_evt = in_hs & S_AXIS_TLAST & (sof_cnt_q == FD_C);

    assign slice      = SW'(beat_idx_q % BW'(R));
    assign last_slice = (slice == LAST_SLICE);
    assign tvalid     = (state_q == SEND) & buf_valid_q;
    assign tx         = tvalid & M_AXIS_TREADY;
    assign line_end   = tx & (beat_idx_q == LAST_BEAT);
    assign fetch_ok   = (state_q == SEND) & (words_q < WPL_W);
    assign brd_rdy    = fetch_ok & (~buf_valid_q | (tx & last_slice));
    assign pop        = brd_rdy & brd_vld;
    assign underrun_set = fetch_ok & ~buf_valid_q & ~brd_vld;

    assign start = (state_q == IDLE) & (credit_q != '0) &
                   (~WAIT_FULL_LINE | (brd_cnt >= WPL_C));

    for (genvar k = 0; k < 2**SW; k++) begin : g_slice
        if (k >= R) begin : g_pad
            assign beat_sel[k] = '0;
        end else if (SLICE_MSB_FIRST) begin : g_msb
            assign beat_sel[k] = buf_q[FDW-1-k*W -: W];
        end else begin : g_lsb
            assign beat_sel[k] = buf_q[k*W +: W];
        end
    end

    assign M_AXIS_TVALID = tvalid;
    assign M_AXIS_TDATA  = beat_sel[slice];
    assign M_AXIS_TSTRB  = '1;
    assign M_AXIS_TLAST  = tvalid & (beat_idx_q == LAST_BEAT);
    assign M_AXIS_USER   = tvalid & (line_idx_q == '0) & (beat_idx_q == '0);
    assign credit_cnt    = credit_q;
    assign underrun_err  = underrun_q;
    assign credit_ovf    = ovf_q;

    always_comb begin
        state_d     = state_q;
        sof_cnt_d   = sof_cnt_q;
        credit_d    = credit_q;
        beat_idx_d  = beat_idx_q;
        words_d     = words_q;
        line_idx_d  = line_idx_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        ovf_d       = ovf_q & ~err_clr;
        underrun_d  = underrun_set | (underrun_q & ~err_clr);

        if (in_hs & S_AXIS_USER & (sof_cnt_q < FD_C)) begin
            sof_cnt_d = sof_cnt_q + FW'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SEND;
                    beat_idx_d = '0;
                    words_d    = '0;
                end
            end
            SEND: begin
                if (tx) begin
                    beat_idx_d = beat_idx_q + BW'(1);
                end
                if (line_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop on the last slice refills the buffer with no bubble.
        if (pop) begin
            buf_d       = brd_din;
            buf_valid_d = 1'b1;
            words_d     = words_q + WW'(1);
        end else if (tx & last_slice) begin
            buf_valid_d = 1'b0;
        end

        if (line_end) begin
            line_idx_d = (line_idx_q == LAST_LINE) ? '0 : line_idx_q + LW'(1);
        end

        case ({credit_evt, start})
            2'b10: begin
                if (credit_q == '1) begin
                    ovf_d = 1'b1;
                end else begin
                    credit_d = credit_q + CREDIT_W'(1);
                end
            end
            2'b01:   credit_d = credit_q - CREDIT_W'(1);
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state_q     <= IDLE;
            sof_cnt_q   <= '0;
            credit_q    <= '0;
            beat_idx_q  <= '0;
            words_q     <= '0;
            line_idx_q  <= '0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sof_cnt_q   <= sof_cnt_d;
            credit_q    <= credit_d;
            beat_idx_q  <= beat_idx_d;
            words_q     <= words_d;
            line_idx_q  <= line_idx_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            underrun_q  <= underrun_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule
